// File: rtl/fc_argmax_decision_if.sv
// Score stream in / decision out bundle for fc_argmax_decision.
// ARGMAX_MARGIN_EN adds the winner-to-runner-up margin signal.
interface fc_argmax_decision_if #(
  parameter int DATA_W = 12,
  parameter int IDX_W  = 4
);
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              clear;
  logic [IDX_W-1:0]  decision;
  logic [DATA_W-1:0] max_value;
  logic              valid_out;
  logic              busy;
`ifdef ARGMAX_MARGIN_EN
  logic [DATA_W:0]   margin;

  modport master (
    output valid_in, data_in, clear,
    input  decision, max_value, valid_out,
    input  busy, margin
  );

  modport slave (
    input  valid_in, data_in, clear,
    output decision, max_value, valid_out,
    output busy, margin
  );
`else
  modport master (
    output valid_in, data_in, clear,
    input  decision, max_value, valid_out,
    input  busy
  );

  modport slave (
    input  valid_in, data_in, clear,
    output decision, max_value, valid_out,
    output busy
  );
`endif
endinterface

// File: rtl/fc_argmax_decision.sv
// Running signed argmax over one FC score per class; emits winner per frame.
// ARGMAX_MARGIN_EN also tracks the runner-up and reports max - second.
module fc_argmax_decision #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 12,
  parameter int IDX_W       = 4
) (
  input logic clk,
  input logic rst_n,
  fc_argmax_decision_if.slave bus
);

  typedef logic signed [DATA_W-1:0] score_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST = IDX_W'(NUM_CLASSES - 1);

  idx_t   cnt, cnt_nx;
  idx_t   run_idx, run_idx_nx;
  idx_t   dec, dec_nx;
  score_t run_max, run_max_nx;
  score_t max_q, max_nx;
  logic   vout, vout_nx;

  score_t din;
  logic   acc, first, last;
  logic   take, fin, step;
  score_t win_val;
  idx_t   win_idx;

  assign din   = $signed(bus.data_in);
  assign acc   = bus.valid_in & ~bus.clear;
  assign first = (cnt == '0);
  assign last  = (cnt == LAST);
  assign fin   = acc & last;
  assign step  = acc & ~last;

  // Strict compare keeps the earliest index on ties.
  assign take    = first || (din > run_max);
  assign win_val = take ? din : run_max;
  assign win_idx = take ? cnt : run_idx;

`ifdef ARGMAX_MARGIN_EN
  localparam score_t MOST_NEG =
    {1'b1, {(DATA_W-1){1'b0}}};

  score_t          sec, sec_nx, sec_win;
  logic [DATA_W:0] mar, mar_nx;

  // Displaced max becomes runner-up; equal-to-max lands here too.
  always_comb begin
    sec_win = sec;
    if (first)
      sec_win = MOST_NEG;
    else if (din > run_max)
      sec_win = run_max;
    else if (din > sec)
      sec_win = din;
  end
`endif

  always_comb begin
    cnt_nx     = cnt;
    run_max_nx = run_max;
    run_idx_nx = run_idx;
    dec_nx     = dec;
    max_nx     = max_q;
    vout_nx    = 1'b0;
`ifdef ARGMAX_MARGIN_EN
    sec_nx     = sec;
    mar_nx     = mar;
`endif
    unique case (1'b1)
      bus.clear: begin
        cnt_nx     = '0;
        run_max_nx = '0;
        run_idx_nx = '0;
`ifdef ARGMAX_MARGIN_EN
        sec_nx     = MOST_NEG;
`endif
      end
      fin: begin
        cnt_nx     = '0;
        run_max_nx = '0;
        run_idx_nx = '0;
        dec_nx     = win_idx;
        max_nx     = win_val;
        vout_nx    = 1'b1;
`ifdef ARGMAX_MARGIN_EN
        sec_nx     = MOST_NEG;
        mar_nx     = {win_val[DATA_W-1], win_val}
                   - {sec_win[DATA_W-1], sec_win};
`endif
      end
      step: begin
        cnt_nx     = cnt + IDX_W'(1);
        run_max_nx = win_val;
        run_idx_nx = win_idx;
`ifdef ARGMAX_MARGIN_EN
        sec_nx     = sec_win;
`endif
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      run_max <= '0;
      run_idx <= '0;
      dec     <= '0;
      max_q   <= '0;
      vout    <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      run_max <= run_max_nx;
      run_idx <= run_idx_nx;
      dec     <= dec_nx;
      max_q   <= max_nx;
      vout    <= vout_nx;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec <= MOST_NEG;
      mar <= '0;
    end else begin
      sec <= sec_nx;
      mar <= mar_nx;
    end
  end

  assign bus.margin = mar;
`endif

  assign bus.decision  = dec;
  assign bus.max_value = max_q;
  assign bus.valid_out = vout;
  assign bus.busy      = (cnt != '0);

endmodule

// File: tb/tb_fc_argmax_decision.sv
// Bench for fc_argmax_decision: table frames, gaps, clear, async reset.
// Expected results are queued on the last score and popped on valid_out.
module tb_fc_argmax_decision;

  localparam int N  = 10;
  localparam int DW = 12;
  localparam int IW = 4;

  typedef int frame_t [N];

  typedef struct {
    frame_t scores;
    int     idx;
    int     maxv;
  } vec_t;

  typedef struct {
    int idx;
    int maxv;
    int marg;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  int   pulses;
  exp_t sb[$];
  vec_t tbl [6];

  fc_argmax_decision_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  fc_argmax_decision #(
    .NUM_CLASSES(N),
    .DATA_W(DW),
    .IDX_W(IW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  // Reference: first occurrence of the maximum; runner-up is best of the rest.
  function automatic exp_t model(input frame_t s);
    exp_t e;
    int   w;
    int   sec;
    w = 0;
    for (int i = 1; i < N; i++)
      if (s[i] > s[w]) w = i;
    sec = -(1 << (DW - 1));
    for (int i = 0; i < N; i++)
      if (i != w && s[i] > sec) sec = s[i];
    e.idx  = w;
    e.maxv = s[w];
    e.marg = s[w] - sec;
    e.cyc  = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus.valid_in = 1'b0;
      bus.clear    = 1'b0;
    end
  endtask

  task automatic send_frame(input frame_t s, input int maxgap,
                            input bit chk_busy, input bit push,
                            input int idx, input int maxv);
    exp_t e;
    int   gap;
    for (int i = 0; i < N; i++) begin
      tick();
      bus.valid_in = 1'b1;
      bus.clear    = 1'b0;
      bus.data_in  = DW'(s[i]);
      if (i == N - 1 && push) begin
        e      = model(s);
        e.idx  = idx;
        e.maxv = maxv;
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
      if (chk_busy) begin
        @(negedge clk);
        chk("busy_sample", int'(bus.busy), int'(i != 0));
      end
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        tick();
        bus.valid_in = 1'b0;
        if (chk_busy) begin
          @(negedge clk);
          chk("busy_gap", int'(bus.busy), int'(i != N - 1));
        end
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_decision"}, int'(bus.decision), 0);
    chk({tag, "_max"}, int'(bus.max_value), 0);
    chk({tag, "_valid_out"}, int'(bus.valid_out), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
`ifdef ARGMAX_MARGIN_EN
    chk({tag, "_margin"}, int'(bus.margin), 0);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.valid_out) begin
      exp_t e;
      pulses++;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL spurious_valid_out: got pulse expected none (cycle %0d)",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("decision", int'(bus.decision), e.idx);
        chk("max_value", int'($signed(bus.max_value)), e.maxv);
`ifdef ARGMAX_MARGIN_EN
        chk("margin", int'(bus.margin), e.marg);
`endif
      end
    end
  end

  initial begin
    frame_t pre;
    int     wait_n;
    errors = 0;
    checks = 0;
    pulses = 0;

    tbl[0].scores = '{5, -3, 100, 7, 100, 0, 0, 0, 0, 0};
    tbl[0].idx = 2;   tbl[0].maxv = 100;
    tbl[1].scores = '{-50, -10, -2048, -9, -11, -300, -1, -4, -7, -8};
    tbl[1].idx = 6;   tbl[1].maxv = -1;
    tbl[2].scores = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 2047};
    tbl[2].idx = 9;   tbl[2].maxv = 2047;
    tbl[3].scores = '{2047, 0, -1, 2047, 5, 5, 5, 5, 5, 5};
    tbl[3].idx = 0;   tbl[3].maxv = 2047;
    tbl[4].scores = '{-2048, -2048, -2048, -2048, -2048,
                      -2048, -2048, -2048, -2048, -2048};
    tbl[4].idx = 0;   tbl[4].maxv = -2048;
    tbl[5].scores = '{3, -7, 12, 12, -100, 40, 39, 40, -2048, 1};
    tbl[5].idx = 5;   tbl[5].maxv = 40;

    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.clear    = 1'b0;
    bus.data_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // All table frames back-to-back with no idle cycle between them.
    for (int k = 0; k < 6; k++)
      send_frame(tbl[k].scores, 0, 1'b1, 1'b1, tbl[k].idx, tbl[k].maxv);
    idle(1);
    @(negedge clk);
    chk("busy_after_b2b", int'(bus.busy), 0);
    idle(3);

    // Same scores with random idle gaps.
    for (int k = 0; k < 3; k++) begin
      send_frame(tbl[k].scores, 3, 1'b1, 1'b1, tbl[k].idx, tbl[k].maxv);
      idle(1);
      @(negedge clk);
      chk("busy_after_gap", int'(bus.busy), 0);
    end
    idle(3);

    // Abort after 4 scores; clear together with a 5th sample.
    pre = '{1500, 1, 2, 3, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.valid_in = 1'b1;
      bus.data_in  = DW'(pre[i]);
    end
    tick();
    bus.valid_in = 1'b1;
    bus.clear    = 1'b1;
    bus.data_in  = DW'(1900);
    tick();
    bus.valid_in = 1'b0;
    bus.clear    = 1'b0;
    @(negedge clk);
    chk("busy_after_clear", int'(bus.busy), 0);
    chk("decision_hold", int'(bus.decision), tbl[2].idx);
    chk("max_hold", int'($signed(bus.max_value)), tbl[2].maxv);
    send_frame(tbl[5].scores, 0, 1'b0, 1'b1, tbl[5].idx, tbl[5].maxv);
    idle(4);

    // Async reset in the middle of a frame.
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.valid_in = 1'b1;
      bus.data_in  = DW'(1900 - i);
    end
    @(posedge clk);
    #3;
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(tbl[0].scores, 0, 1'b1, 1'b1, tbl[0].idx, tbl[0].maxv);
    idle(2);

    wait_n = 0;
    while (sb.size() != 0 && wait_n < 50) begin
      @(posedge clk);
      wait_n++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL pending_results: got %0d outstanding expected 0",
               sb.size());
    end
    checks++;
    if (pulses != 11) begin
      errors++;
      $display("FAIL pulse_count: got %0d expected 11", pulses);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_argmax_decision.md
Name: fc_argmax_decision

Overview:
Consumer end of the fully-connected output stream. Collects one score per class from the FC stage's data/valid stream and tracks the running maximum. At the end of each frame it emits the winning class index, which is the recognised digit, together with its score. It sits between the FC stage and the top-level result register/display logic.

Parameters:
NUM_CLASSES, 10, number of FC scores per frame (classes 0..NUM_CLASSES-1, in arrival order)
DATA_W, 12, score width; two's-complement signed
IDX_W, 4, class index width; must satisfy 2^IDX_W >= NUM_CLASSES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  score strobe from FC stage; one score per high cycle
data_in  input  DATA_W  FC score, interpreted as signed
clear  input  1  synchronous frame abort
decision  output  IDX_W  index of maximum score of last completed frame
max_value  output  DATA_W  score of that class
valid_out  output  1  one-cycle pulse: decision/max_value updated
busy  output  1  high while a frame is partially received

Behaviour:
- Reset (async, rst_n=0): class counter=0, running max=0, running idx=0, decision=0, max_value=0, valid_out=0, busy=0. Reset mid-frame discards the partial frame.
- Class counter, IDX_W bits, counts accepted scores 0..NUM_CLASSES-1. busy = (counter != 0), registered-equivalent (derived from counter).
- valid_in=1, counter=0: running max<=data_in, running idx<=0, counter<=1. First sample always loads and is never compared.
- valid_in=1, 0<counter<NUM_CLASSES-1: if data_in > running max (signed, strict), running max<=data_in and running idx<=counter. Ties keep the earlier (lower) index. counter increments.
- valid_in=1, counter==NUM_CLASSES-1 (last score): final compare includes the current sample. decision/max_value <= final winner, valid_out<=1 next cycle, counter<=0.
- Latency: valid_out rises on the clock edge that samples the last score, i.e. visible the cycle after the last valid_in. It is high for exactly one cycle.
- valid_in=0: no state change; valid_out<=0. Gaps of any length within a frame are allowed.
- Back-to-back frames: first score of the next frame may arrive the cycle immediately after the last score. It loads as a fresh frame start and the previous result is unaffected.
- clear=1: counter<=0, running max/idx<=0, valid_out<=0. clear has priority over a simultaneous valid_in; that sample is dropped. decision/max_value hold the last completed result.
- decision/max_value change only on frame completion or reset.
- Signed compare is done on full DATA_W; no saturation or width growth.

Optional Feature:
ARGMAX_MARGIN_EN
- Defined: adds output port margin, DATA_W+1 bits, unsigned. It also tracks a running second-best score.
  - On a new max, the old max moves to second-best.
  - Otherwise, if data_in > second-best, second-best <= data_in.
  - On the first sample, second-best = most negative DATA_W value.
  - At frame end, margin <= max - second-best, computed in DATA_W+1 bits and updated with decision. Reset value is 0.
  - Ties with the max: the later sample goes to second-best, so margin=0.
- Undefined: no margin port and no second-best logic; all other behaviour is identical.

Test Plan:
- Frame 5,-3,100,7,100,0,0,0,0,0 -> valid_out one cycle after 10th sample, decision=2, max_value=100 (tie keeps lower index); margin=0 if ARGMAX_MARGIN_EN.
- All-negative frame -50,-10,-2048,-9,-11,-300,-1,-4,-7,-8 -> decision=6, max_value=-1 (0xFFF), not 0.
- Two back-to-back frames with no idle cycle, maxima at index 9 then index 0 -> two valid_out pulses 10 cycles apart, decision=9 then 0.
- Scores with random 0-3 cycle gaps in valid_in -> same result as a gapless frame; busy high from 1st score until the cycle after the 10th score.
- clear after 4 scores, asserted together with a 5th valid_in, then a full 10-score frame -> the 5th sample is dropped, only the new frame is evaluated, decision reflects the new frame, and no spurious valid_out.
- rst_n low after 6 scores -> all outputs 0 immediately; the next full frame produces a correct decision with no carry-over.
